// File: rtl/ext_mem_arbiter.sv
// Two-port arbiter for one external memory with a ready handshake and a per-phase timeout.
// Define ARB_ROUND_ROBIN_EN for alternating grants on contention; otherwise port 0 always wins.
module ext_mem_arbiter #(
    parameter int data_width    = 16,
    parameter int address_width = 16,
    parameter int TIMEOUT       = 15
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     read0,
    input  logic                     read1,
    input  logic [address_width-1:0] addr0,
    input  logic [address_width-1:0] addr1,
    input  logic [data_width-1:0]    wdata0,
    input  logic [data_width-1:0]    wdata1,
    output logic [data_width-1:0]    rdata,
    output logic                     ack0,
    output logic                     ack1,
    output logic                     err,
    output logic                     cs_ext_mem,
    output logic                     read,
    output logic [address_width-1:0] address,
    output logic [data_width-1:0]    mem_wdata,
    output logic                     mem_oe,
    input  logic [data_width-1:0]    mem_rdata,
    input  logic                     ready_ext_mem,
    output logic [1:0]               state_dbg
);

    // Handshake: a port holds req until it sees its one-cycle ack; the memory is
    // selected by cs_ext_mem, drops ready_ext_mem to accept, and raises it to complete.

    localparam int CW = ($clog2(TIMEOUT + 1) > 4) ? $clog2(TIMEOUT + 1) : 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t                   state_q, state_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic                     grant_q, grant_d;
    logic                     cs_q, cs_d;
    logic                     read_q, read_d;
    logic [address_width-1:0] addr_q, addr_d;
    logic [data_width-1:0]    wdata_q, wdata_d;
    logic                     oe_q, oe_d;
    logic [data_width-1:0]    rdata_q, rdata_d;
    logic                     ack0_q, ack0_d;
    logic                     ack1_q, ack1_d;
    logic                     err_q, err_d;
    logic                     win;
    logic                     timeout_hit;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    // On contention the port that was not granted last wins.
    always_comb begin
        if (req0 && req1) win = ~last_q;
        else              win = req1 & ~req0;
    end
`else
    always_comb win = ~req0;
`endif

    assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        grant_d = grant_q;
        cs_d    = cs_q;
        read_d  = read_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        err_d   = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    grant_d = win;
                    read_d  = win ? read1  : read0;
                    addr_d  = win ? addr1  : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    cs_d    = 1'b1;
                    cnt_d   = '0;
                    state_d = ISSUE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = win;
`endif
                end
            end
            ISSUE: begin
                if (!ready_ext_mem) begin
                    cnt_d   = '0;
                    state_d = WAIT;
                end else if (timeout_hit) begin
                    cs_d    = 1'b0;
                    err_d   = 1'b1;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            WAIT: begin
                if (ready_ext_mem) begin
                    if (read_q) rdata_d = mem_rdata;
                    cs_d    = 1'b0;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end else if (timeout_hit) begin
                    cs_d    = 1'b0;
                    err_d   = 1'b1;
                    ack0_d  = ~grant_q;
                    ack1_d  = grant_q;
                    cnt_d   = '0;
                    state_d = DONE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            DONE: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: begin
                cs_d    = 1'b0;
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
        // The data bus is driven only during a selected write.
        oe_d = cs_d & ~read_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            grant_q <= 1'b0;
            cs_q    <= 1'b0;
            read_q  <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            oe_q    <= 1'b0;
            rdata_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err_q   <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            cs_q    <= cs_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            oe_q    <= oe_d;
            rdata_q <= rdata_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            err_q   <= err_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q  <= last_d;
`endif
        end
    end

    assign cs_ext_mem = cs_q;
    assign read       = read_q;
    assign address    = addr_q;
    assign mem_wdata  = wdata_q;
    assign mem_oe     = oe_q;
    assign rdata      = rdata_q;
    assign ack0       = ack0_q;
    assign ack1       = ack1_q;
    assign err        = err_q;
    assign state_dbg  = state_q;

endmodule

// File: doc/ext_mem_arbiter.md
EXT_MEM_ARBITER -- requirements
Module: ext_mem_arbiter

Interface
REQ-001 The block SHALL have parameter data_width, default 16, meaning the data bus width.
REQ-002 The block SHALL have parameter address_width, default 16, meaning the address bus width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum number of cycles the block waits for each ready phase.
REQ-004 The block SHALL have port clk  in  1  single system clock, all state on posedge.
REQ-005 The block SHALL have port rst  in  1  reset, asynchronous, active-high.
REQ-006 The block SHALL have ports req0/req1  in  1  transaction request from port 0 (CPU) and port 1 (DMA/debug).
REQ-007 The block SHALL have ports read0/read1  in  1  per-port direction, 1 = read, 0 = write.
REQ-008 The block SHALL have ports addr0/addr1  in  address_width  per-port address.
REQ-009 The block SHALL have ports wdata0/wdata1  in  data_width  per-port write data.
REQ-010 The block SHALL have port rdata  out  data_width  captured read data, valid while an ack is high.
REQ-011 The block SHALL have ports ack0/ack1  out  1  one-cycle completion pulse per port.
REQ-012 The block SHALL have port err  out  1  timeout flag, valid with ack.
REQ-013 The block SHALL have port cs_ext_mem  out  1  memory chip select.
REQ-014 The block SHALL have port read  out  1  memory direction.
REQ-015 The block SHALL have port address  out  address_width  memory address.
REQ-016 The block SHALL have ports mem_wdata  out  data_width and mem_oe  out  1, giving write data and its tristate enable for the shared data bus.
REQ-017 The block SHALL have port mem_rdata  in  data_width  data bus input.
REQ-018 The block SHALL have port ready_ext_mem  in  1  memory ready.

Function
REQ-019 The block SHALL implement FSM states IDLE, ISSUE, WAIT and DONE, with all outputs registered.
REQ-020 In IDLE, with any req high, the block SHALL select a winner and latch its read, addr and wdata, assert cs_ext_mem, and go to ISSUE on the next edge.
REQ-021 Arbitration without ARB_ROUND_ROBIN_EN SHALL be fixed priority, with port 0 winning.
REQ-022 In ISSUE, cs_ext_mem SHALL be held, and the block SHALL go to WAIT on the first cycle ready_ext_mem==0.
REQ-023 In WAIT, on ready_ext_mem==1, the block SHALL capture mem_rdata into rdata if the transaction is a read, deassert cs_ext_mem on the same edge, and go to DONE.
REQ-024 In DONE, the block SHALL pulse ack of the granted port for exactly one cycle and return to IDLE; a new grant is possible the following cycle.
REQ-025 mem_oe SHALL be 1 only while cs_ext_mem==1 and read==0.
REQ-026 address, read and mem_wdata SHALL be stable from the assertion of cs_ext_mem until it is deasserted.
REQ-027 A 4-bit-or-wider cycle counter SHALL reset on each state entry; if ISSUE or WAIT lasts TIMEOUT cycles, the block SHALL drop cs, go to DONE, and assert err with ack; rdata is then unchanged.
REQ-028 A req deasserted mid-transaction SHALL NOT abort the transaction; ack is still issued.
REQ-029 If req is still high after its ack, it SHALL be treated as a new request.
REQ-030 Simultaneous req0 and req1 SHALL result in exactly one grant; the loser waits with no lost request.
REQ-031 The minimum transaction time SHALL be 4 cycles from req sampled to ack.

Reset
REQ-032 On rst, the block SHALL go to IDLE immediately, with cs_ext_mem=0, read=1, address=0, mem_wdata=0, mem_oe=0, rdata=0, ack0=ack1=0, err=0, and counter=0.
REQ-033 Reset asserted mid-transaction SHALL drop cs_ext_mem asynchronously and issue no ack for the aborted transaction.
REQ-034 After reset, the round-robin pointer SHALL favour port 0.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN defined: a 1-bit last-grant pointer SHALL be kept, and on a simultaneous request the port not granted last SHALL win.
REQ-036 Macro ARB_ROUND_ROBIN_EN undefined: fixed priority SHALL apply with port 0 always winning, and the pointer logic SHALL be absent.

Verification
REQ-037 Write: req0=1, read0=0, addr0=0x0009, wdata0=0x0002 -> cs asserted, mem_oe=1, address=0x0009, mem_wdata=0x0002, ack0 exactly 1 cycle, err=0, and subsequent read of 0x0009 returns 0x0002.
REQ-038 Read: memory word 0x0008 = 0x1234, req1 read addr1=0x0008 -> rdata=0x1234 with ack1, mem_oe=0 throughout.
REQ-039 Contention: req0 and req1 both held high for 4 transactions -> without macro, ack0 only; with macro, ack0, ack1, ack0, ack1 alternating.
REQ-040 Timeout: ready_ext_mem stuck 1 after cs -> after TIMEOUT=15 cycles in ISSUE, cs=0, and ack with err=1.
REQ-041 Reset mid-op: rst asserted while in WAIT -> cs_ext_mem=0 in the same cycle, no ack, and the next req is serviced normally.
REQ-042 Glitch request: req0 pulsed for 1 cycle -> full transaction completes and ack0 is issued.
